// File: rtl/avr_gpio_bank.sv
// Multi-port AVR GPIO bank with PIN/DDR/PORT registers, two-flop input synchroniser and PIN-write toggle.
// Define GPIO_PCINT_EN to add the per-port pin-change mask, the shared PCIFR flag register and a level irq.
module avr_gpio_bank #(
  parameter int BASE_ADDR  = 22,
  parameter int NUM_PORTS  = 2,
  parameter int PORT_WIDTH = 6,
  parameter int PCMSK_ADDR = 32,
  parameter int PCIFR_ADDR = 36
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [5:0]                      io_addr,
  inout  logic [7:0]                      io_data,
  input  logic                            io_read,
  input  logic                            io_write,
  inout  logic [NUM_PORTS*PORT_WIDTH-1:0] gpio,
  output logic                            irq
);

  typedef logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] bank_t;

  bank_t      ddr;
  bank_t      port_q;
  bank_t      sync1;
  bank_t      sync2;
  logic       rd_hit;
  logic [7:0] rdata;

`ifdef GPIO_PCINT_EN
  bank_t                prev;
  bank_t                pcmsk;
  logic [NUM_PORTS-1:0] pcifr;
  logic [NUM_PORTS-1:0] pcifr_next;
  logic [NUM_PORTS-1:0] change;
  logic                 wr_pcifr;
  logic                 irq_q;
`endif

  always_comb begin
    rd_hit = 1'b0;
    rdata  = 8'h00;
    if (io_read) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (io_addr == 6'(BASE_ADDR - 3*k)) begin
          rd_hit = 1'b1;
          rdata  = 8'(sync2[k]);
        end
        if (io_addr == 6'(BASE_ADDR - 3*k + 1)) begin
          rd_hit = 1'b1;
          rdata  = 8'(ddr[k]);
        end
        if (io_addr == 6'(BASE_ADDR - 3*k + 2)) begin
          rd_hit = 1'b1;
          rdata  = 8'(port_q[k]);
        end
`ifdef GPIO_PCINT_EN
        if (io_addr == 6'(PCMSK_ADDR + k)) begin
          rd_hit = 1'b1;
          rdata  = 8'(pcmsk[k]);
        end
`endif
      end
`ifdef GPIO_PCINT_EN
      if (io_addr == 6'(PCIFR_ADDR)) begin
        rd_hit = 1'b1;
        rdata  = 8'(pcifr);
      end
`endif
    end
  end

  assign io_data = rd_hit ? rdata : 8'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ddr    <= '0;
      port_q <= '0;
      sync1  <= '0;
      sync2  <= '0;
    end else begin
      sync1 <= gpio;
      sync2 <= sync1;
      if (io_write) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          // PIN is read-only; a write to its address flips the selected PORT bits
          if (io_addr == 6'(BASE_ADDR - 3*k))
            port_q[k] <= port_q[k] ^ io_data[PORT_WIDTH-1:0];
          if (io_addr == 6'(BASE_ADDR - 3*k + 1))
            ddr[k] <= io_data[PORT_WIDTH-1:0];
          if (io_addr == 6'(BASE_ADDR - 3*k + 2))
            port_q[k] <= io_data[PORT_WIDTH-1:0];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    for (genvar i = 0; i < PORT_WIDTH; i++) begin : g_pin
      assign gpio[k*PORT_WIDTH + i] = ddr[k][i] ? port_q[k][i] : 1'bz;
    end
  end

`ifdef GPIO_PCINT_EN
  assign wr_pcifr = io_write && (io_addr == 6'(PCIFR_ADDR));

  // a new change event beats a same-cycle software clear
  always_comb begin
    change     = '0;
    pcifr_next = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      change[k]     = |((sync2[k] ^ prev[k]) & pcmsk[k]);
      pcifr_next[k] = change[k] | (pcifr[k] & ~(wr_pcifr & io_data[k]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= '0;
      pcmsk <= '0;
      pcifr <= '0;
      irq_q <= 1'b0;
    end else begin
      prev  <= sync2;
      pcifr <= pcifr_next;
      irq_q <= |pcifr;
      if (io_write) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          if (io_addr == 6'(PCMSK_ADDR + k))
            pcmsk[k] <= io_data[PORT_WIDTH-1:0];
        end
      end
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule
